// File: rtl/lp_ctrl_pkg.sv
// rtl/lp_ctrl_pkg.sv - shared power-control types, polarities and counter sizing
package lp_ctrl_pkg;

   typedef enum logic [2:0] {
      PS_OFF      = 3'd0,
      PS_PWRUP    = 3'd1,
      PS_WAIT_ON  = 3'd2,
      PS_DEISO    = 3'd3,
      PS_ON       = 3'd4,
      PS_ISO      = 3'd5,
      PS_WAIT_OFF = 3'd6
   } pwr_state_e;

   // Cell pin polarities: header SLEEP high = off, fence EN high = clamped,
   // level-shifter ISOLN low = isolated.
   localparam logic SEG_OFF      = 1'b1;
   localparam logic ISO_ACTIVE   = 1'b1;
   localparam logic ISOLN_ACTIVE = 1'b0;

   // Width of a counter that must reach the largest of the three intervals.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// rtl/pwr_seq_timer.sv - shared saturating interval counter with terminal-count compare
module pwr_seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] tc_val,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Reload on clear, otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q != {W{1'b1}}) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/pwr_domain_seq.sv
// rtl/pwr_domain_seq.sv - staggered header / isolation sequencer for one switchable domain
module pwr_domain_seq #(
   parameter int NSEG        = 4,
   parameter int STAGGER     = 2,
   parameter int ISO_SETUP   = 1,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic            CK,
   input  logic            RST,
   input  logic            PWR_REQ,
   input  logic            SLEEPOUT_ACK,
   output logic [NSEG-1:0] SLEEP,
   output logic            ISO_EN,
   output logic            ISOLN,
   output logic            PWR_ACK,
   output logic            BUSY,
   output logic            ERR
);
   import lp_ctrl_pkg::*;

   localparam int CW = cnt_width(STAGGER, ISO_SETUP, ACK_TIMEOUT);

   localparam logic [2:0] ST_OFF      = PS_OFF;
   localparam logic [2:0] ST_PWRUP    = PS_PWRUP;
   localparam logic [2:0] ST_WAIT_ON  = PS_WAIT_ON;
   localparam logic [2:0] ST_DEISO    = PS_DEISO;
   localparam logic [2:0] ST_ON       = PS_ON;
   localparam logic [2:0] ST_ISO      = PS_ISO;
   localparam logic [2:0] ST_WAIT_OFF = PS_WAIT_OFF;

   localparam logic [CW-1:0] TC_STAGGER = CW'(STAGGER - 1);
   localparam logic [CW-1:0] TC_ISO     = CW'(ISO_SETUP - 1);
   localparam logic [CW-1:0] TC_ACK     = CW'(ACK_TIMEOUT - 1);

   localparam logic [NSEG-1:0] ALL_OFF = {NSEG{SEG_OFF}};

   logic [2:0]      state_q, state_d;
   logic [NSEG-1:0] sleep_q, sleep_d, sleep_step;
   logic            err_q, err_d;
   logic            iso_en_q, iso_en_d;
   logic            isoln_q, isoln_d;
   logic            pwr_ack_q, pwr_ack_d;
   logic            busy_q, busy_d;
   logic            step;
   logic            clr;
   logic            tc;
   logic [CW-1:0]   tc_val;

   // Next state and segment pattern. Segments turn on lowest index first, so a
   // left shift of the SLEEP vector releases exactly the next segment; the
   // vector reaching zero means the last segment has just been released.
   always_comb begin
      state_d    = state_q;
      sleep_d    = sleep_q;
      err_d      = err_q;
      step       = 1'b0;
      sleep_step = sleep_q << 1;
      case (state_q)
         ST_OFF: begin
            if (PWR_REQ && !err_q) begin
               sleep_d = sleep_step;
               state_d = (sleep_step == '0) ? ST_WAIT_ON : ST_PWRUP;
            end
         end
         ST_PWRUP: begin
            if (tc) begin
               sleep_d = sleep_step;
               step    = 1'b1;
               if (sleep_step == '0) state_d = ST_WAIT_ON;
            end
         end
         ST_WAIT_ON: begin
            if (!SLEEPOUT_ACK) begin
               state_d = ST_DEISO;
            end else if (tc) begin
               err_d   = 1'b1;
               sleep_d = ALL_OFF;
               state_d = ST_WAIT_OFF;
            end
         end
         ST_DEISO: begin
            if (tc) state_d = ST_ON;
         end
         ST_ON: begin
            if (!PWR_REQ) state_d = ST_ISO;
         end
         ST_ISO: begin
            if (tc) begin
               sleep_d = ALL_OFF;
               state_d = ST_WAIT_OFF;
            end
         end
         ST_WAIT_OFF: begin
            if (SLEEPOUT_ACK) begin
               state_d = ST_OFF;
            end else if (tc) begin
               err_d   = 1'b1;
               state_d = ST_OFF;
            end
         end
         default: begin
            state_d = ST_OFF;
            sleep_d = ALL_OFF;
         end
      endcase
   end

   // Interval select for the shared timer and its reload on entry/step.
   always_comb begin
      clr = step || (state_d != state_q);
      case (state_q)
         ST_PWRUP:                tc_val = TC_STAGGER;
         ST_DEISO, ST_ISO:        tc_val = TC_ISO;
         ST_WAIT_ON, ST_WAIT_OFF: tc_val = TC_ACK;
         default:                 tc_val = '0;
      endcase
   end

   // Registered outputs decoded from the state being entered; isolation is
   // released only in ON, which is reached only with every segment on.
   always_comb begin
      pwr_ack_d = (state_d == ST_ON);
      busy_d    = (state_d != ST_ON) && (state_d != ST_OFF);
      iso_en_d  = (state_d == ST_ON) ? ~ISO_ACTIVE : ISO_ACTIVE;
      isoln_d   = (state_d == ST_ON) ? ~ISOLN_ACTIVE : ISOLN_ACTIVE;
   end

   // State and output registers.
   always_ff @(posedge CK) begin
      if (RST) begin
         state_q   <= ST_OFF;
         sleep_q   <= ALL_OFF;
         err_q     <= 1'b0;
         iso_en_q  <= ISO_ACTIVE;
         isoln_q   <= ISOLN_ACTIVE;
         pwr_ack_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sleep_q   <= sleep_d;
         err_q     <= err_d;
         iso_en_q  <= iso_en_d;
         isoln_q   <= isoln_d;
         pwr_ack_q <= pwr_ack_d;
         busy_q    <= busy_d;
      end
   end

   pwr_seq_timer #(.W(CW)) u_timer (
      .clk    (CK),
      .rst    (RST),
      .clr    (clr),
      .tc_val (tc_val),
      .tc     (tc)
   );

   assign SLEEP   = sleep_q;
   assign ISO_EN  = iso_en_q;
   assign ISOLN   = isoln_q;
   assign PWR_ACK = pwr_ack_q;
   assign BUSY    = busy_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_pwr_domain_seq.sv
// tb/tb_pwr_domain_seq.sv - bench for pwr_domain_seq against a timing-formula model
module tb_pwr_domain_seq;

   localparam int NSEG        = 4;
   localparam int STAGGER     = 2;
   localparam int ISO_SETUP   = 1;
   localparam int ACK_TIMEOUT = 15;
   localparam int B_STAGGER   = 3;
   localparam int B_ISO       = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b;
   logic       ack_a, ack_b;
   logic [3:0] sleep_a;
   logic [0:0] sleep_b;
   logic       iso_a, isoln_a, pack_a, busy_a, err_a;
   logic       iso_b, isoln_b, pack_b, busy_b, err_b;
   logic [7:0] hist;
   int         d_sel;
   bit         ack_hold;
   bit         inv_en;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   pwr_domain_seq #(.NSEG(NSEG), .STAGGER(STAGGER), .ISO_SETUP(ISO_SETUP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut_a (
      .CK(clk), .RST(rst), .PWR_REQ(req_a), .SLEEPOUT_ACK(ack_a),
      .SLEEP(sleep_a), .ISO_EN(iso_a), .ISOLN(isoln_a), .PWR_ACK(pack_a), .BUSY(busy_a), .ERR(err_a)
   );

   pwr_domain_seq #(.NSEG(1), .STAGGER(B_STAGGER), .ISO_SETUP(B_ISO), .ACK_TIMEOUT(ACK_TIMEOUT)) dut_b (
      .CK(clk), .RST(rst), .PWR_REQ(req_b), .SLEEPOUT_ACK(ack_b),
      .SLEEP(sleep_b), .ISO_EN(iso_b), .ISOLN(isoln_b), .PWR_ACK(pack_b), .BUSY(busy_b), .ERR(err_b)
   );

   // Header chain model: SLEEPOUT follows the last SLEEP after d_sel cycles.
   always @(posedge clk) hist <= {hist[6:0], sleep_a[3]};
   assign ack_a = ack_hold ? 1'b1 : ((d_sel == 0) ? sleep_a[3] : hist[d_sel-1]);
   assign ack_b = sleep_b[0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Segments released by edge t of a power-up: one at edge 0, then one per STAGGER.
   function automatic logic [3:0] exp_sleep(input int t);
      logic [3:0] v;
      int n;
      v = 4'hF;
      n = t / STAGGER + 1;
      if (n > NSEG) n = NSEG;
      return v << n;
   endfunction

   // Isolation must be active whenever a segment is off or the domain is not acknowledged on.
   always @(negedge clk) begin
      if (inv_en) begin
         chk("inv_a", {iso_a, isoln_a}, (|sleep_a || !pack_a) ? 2'b10 : 2'b01);
         chk("inv_b", {iso_b, isoln_b}, (|sleep_b || !pack_b) ? 2'b10 : 2'b01);
      end
   end

   // mode 0: steady request; 1: 3-cycle low pulse during PWRUP; 2: request drops before ON.
   task automatic pu_a(input int d, input int mode);
      int t_on;
      t_on  = (NSEG - 1) * STAGGER + (d + 1) + ISO_SETUP;
      d_sel = d;
      for (int t = 0; t <= t_on; t++) begin
         case (mode)
            1:       req_a = !(t >= 1 && t <= 3);
            2:       req_a = (t < t_on);
            default: req_a = 1'b1;
         endcase
         tick();
         chk("pu_sleep", sleep_a, exp_sleep(t));
         chk("pu_ack",   pack_a,  (t >= t_on));
         chk("pu_busy",  busy_a,  (t < t_on));
         chk("pu_iso",   iso_a,   (t < t_on));
         chk("pu_isoln", isoln_a, (t >= t_on));
      end
   endtask

   task automatic pd_a(input int d);
      int t_off;
      t_off = ISO_SETUP + d + 1;
      d_sel = d;
      req_a = 1'b0;
      for (int t = 0; t <= t_off; t++) begin
         tick();
         chk("pd_ack",   pack_a,  0);
         chk("pd_iso",   iso_a,   1);
         chk("pd_isoln", isoln_a, 0);
         chk("pd_sleep", sleep_a, (t >= ISO_SETUP) ? 4'hF : 4'h0);
         chk("pd_busy",  busy_a,  (t < t_off));
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_sleep"}, sleep_a, 4'hF);
      chk({tag, "_iso"},   iso_a,   1);
      chk({tag, "_isoln"}, isoln_a, 0);
      chk({tag, "_ack"},   pack_a,  0);
      chk({tag, "_busy"},  busy_a,  0);
      chk({tag, "_err"},   err_a,   0);
   endtask

   initial begin
      int t_err;
      int d, m, hold;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; d_sel = 1; ack_hold = 1'b0; inv_en = 1'b0;
      repeat (3) tick();
      chk_reset_a("rst");
      chk("rst_b_sleep", sleep_b, 1);
      rst = 1'b0;
      inv_en = 1'b1;
      repeat (2) tick();

      pu_a(1, 0);
      pd_a(1);
      pu_a(1, 1);
      pd_a(1);
      pu_a(1, 2);
      pd_a(1);

      req_a = 1'b1;
      repeat (3) tick();
      chk("mid_sleep", sleep_a, 4'hC);
      rst = 1'b1;
      tick();
      chk_reset_a("midrst");
      rst = 1'b0; req_a = 1'b0;
      repeat (2) tick();

      t_err = (NSEG - 1) * STAGGER + ACK_TIMEOUT;
      ack_hold = 1'b1;
      req_a = 1'b1;
      for (int t = 0; t <= t_err; t++) begin
         tick();
         chk("to_err",   err_a,   (t >= t_err));
         chk("to_sleep", sleep_a, (t >= t_err) ? 4'hF : exp_sleep(t));
         chk("to_busy",  busy_a,  1);
      end
      tick();
      chk("to_off_busy",  busy_a,  0);
      chk("to_off_sleep", sleep_a, 4'hF);
      repeat (5) tick();
      chk("blk_busy",  busy_a,  0);
      chk("blk_sleep", sleep_a, 4'hF);
      chk("blk_err",   err_a,   1);
      chk("blk_ack",   pack_a,  0);
      ack_hold = 1'b0; req_a = 1'b0; rst = 1'b1;
      tick();
      chk_reset_a("clr");
      rst = 1'b0;
      repeat (2) tick();

      for (int it = 0; it < 8; it++) begin
         d = $urandom_range(0, 3);
         m = $urandom_range(0, 2);
         pu_a(d, m);
         if (m != 2) begin
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
               tick();
               chk("on_hold", pack_a, 1);
            end
         end
         pd_a($urandom_range(0, 3));
         tick();
         chk("idle_busy", busy_a, 0);
      end

      req_b = 1'b1;
      for (int t = 0; t <= B_ISO + 1; t++) begin
         tick();
         chk("b_pu_sleep", sleep_b, 0);
         chk("b_pu_ack",   pack_b,  (t >= B_ISO + 1));
         chk("b_pu_busy",  busy_b,  (t < B_ISO + 1));
      end
      req_b = 1'b0;
      for (int t = 0; t <= B_ISO + 1; t++) begin
         tick();
         chk("b_pd_ack",   pack_b,  0);
         chk("b_pd_sleep", sleep_b, (t >= B_ISO));
         chk("b_pd_busy",  busy_b,  (t < B_ISO + 1));
      end
      chk("b_err", err_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
